// File: rtl/turfbus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : turfbus_ctrl
// Description : SURF-side TURFbus transaction sequencer. Deserialises request
//               frames from TREQ (START, W, ADDR[19:0], DATA[31:0] if W, MSB
//               first, one bit per clock), runs one single-beat WISHBONE
//               master cycle per frame, then returns a status byte (plus four
//               read-data bytes for reads) on TD, strobed by SREQ.
// Ports       : wbm_clk_i / wbm_rst_n_i  - clock, async active-low reset
//               treq_n_i                  - request line, idles high
//               sreq_n_o, td_o, td_oe_o   - response strobe, byte, enables
//               busy_o, drop_o            - not-idle flag, ignored-start pulse
//               wbm_*                     - WISHBONE master (20b adr, 32b dat)
// Revision    : 1.0 - initial release
// ============================================================================
module turfbus_ctrl #(
  parameter int unsigned WB_TIMEOUT = 255
) (
  input  logic        wbm_clk_i,
  input  logic        wbm_rst_n_i,
  input  logic        treq_n_i,
  output logic        sreq_n_o,
  output logic [7:0]  td_o,
  output logic [7:0]  td_oe_o,
  output logic        busy_o,
  output logic        drop_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [19:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  input  logic        wbm_rty_i
);

  localparam logic [7:0] C_TIMEOUT = WB_TIMEOUT[7:0];

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_ADDR = 3'd2,
    S_DATA = 3'd3,
    S_WB   = 3'd4,
    S_STAT = 3'd5,
    S_RDAT = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;       // bit count, WB wait count or byte index
  logic        w_q, w_d;
  logic [19:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [31:0] rdata_q, rdata_d;   // shifted left one byte per response byte
  logic        sreq_n_q, sreq_n_d;
  logic [7:0]  td_q, td_d;
  logic        oe_q, oe_d;
  logic        drop_q, drop_d;

  logic        w_bit;
  logic        w_term;
  logic        w_tmo;
  logic [7:0]  w_status;

  assign w_bit  = ~treq_n_i;
  assign w_term = wbm_ack_i | wbm_err_i | wbm_rty_i;
  // A termination in the timeout cycle wins because it is tested first below.
  assign w_tmo  = (8'(cnt_q + 8'd1) == C_TIMEOUT);

  always_comb begin
    w_status = 8'h03;
    if (wbm_err_i)      w_status = 8'h01;
    else if (wbm_rty_i) w_status = 8'h02;
    else if (wbm_ack_i) w_status = 8'h00;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    w_d      = w_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    cyc_d    = cyc_q;
    we_d     = we_q;
    rdata_d  = rdata_q;
    sreq_n_d = sreq_n_q;
    td_d     = td_q;
    oe_d     = oe_q;
    drop_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_bit) state_d = S_HDR;
      end
      S_HDR: begin
        w_d     = w_bit;
        cnt_d   = 8'd0;
        state_d = S_ADDR;
      end
      S_ADDR: begin
        adr_d = {adr_q[18:0], w_bit};
        if (cnt_q == 8'd19) begin
          cnt_d   = 8'd0;
          state_d = w_q ? S_DATA : S_WB;
        end else begin
          cnt_d = 8'(cnt_q + 8'd1);
        end
      end
      S_DATA: begin
        dat_d = {dat_q[30:0], w_bit};
        if (cnt_q == 8'd31) begin
          cnt_d   = 8'd0;
          state_d = S_WB;
        end else begin
          cnt_d = 8'(cnt_q + 8'd1);
        end
      end
      S_WB: begin
        drop_d = w_bit;
        // First WB cycle only launches the registered cyc/stb/we.
        if (!cyc_q) begin
          cyc_d = 1'b1;
          we_d  = w_q;
          cnt_d = 8'd0;
        end else if (w_term || w_tmo) begin
          cyc_d    = 1'b0;
          we_d     = 1'b0;
          state_d  = S_STAT;
          sreq_n_d = 1'b0;
          oe_d     = 1'b1;
          td_d     = w_status;
          rdata_d  = (w_term && (w_status == 8'h00)) ? wbm_dat_i : 32'h0;
        end else begin
          cnt_d = 8'(cnt_q + 8'd1);
        end
      end
      S_STAT: begin
        drop_d = w_bit;
        if (w_q) begin
          state_d  = S_IDLE;
          sreq_n_d = 1'b1;
          oe_d     = 1'b0;
          td_d     = 8'h00;
        end else begin
          state_d = S_RDAT;
          cnt_d   = 8'd0;
          td_d    = rdata_q[31:24];
          rdata_d = {rdata_q[23:0], 8'h00};
        end
      end
      S_RDAT: begin
        drop_d = w_bit;
        if (cnt_q == 8'd3) begin
          state_d  = S_IDLE;
          sreq_n_d = 1'b1;
          oe_d     = 1'b0;
          td_d     = 8'h00;
        end else begin
          cnt_d   = 8'(cnt_q + 8'd1);
          td_d    = rdata_q[31:24];
          rdata_d = {rdata_q[23:0], 8'h00};
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wbm_clk_i or negedge wbm_rst_n_i) begin
    if (!wbm_rst_n_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= 8'd0;
      w_q      <= 1'b0;
      adr_q    <= 20'h0;
      dat_q    <= 32'h0;
      cyc_q    <= 1'b0;
      we_q     <= 1'b0;
      rdata_q  <= 32'h0;
      sreq_n_q <= 1'b1;
      td_q     <= 8'h00;
      oe_q     <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      w_q      <= w_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      cyc_q    <= cyc_d;
      we_q     <= we_d;
      rdata_q  <= rdata_d;
      sreq_n_q <= sreq_n_d;
      td_q     <= td_d;
      oe_q     <= oe_d;
      drop_q   <= drop_d;
    end
  end

  assign sreq_n_o  = sreq_n_q;
  assign td_o      = td_q;
  assign td_oe_o   = {8{oe_q}};
  assign busy_o    = (state_q != S_IDLE);
  assign drop_o    = drop_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = we_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign wbm_sel_o = 4'hF;

endmodule
`default_nettype wire

// File: tb/tb_turfbus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_turfbus_ctrl
// Description : Self-checking bench for turfbus_ctrl. Serialises frames onto
//               TREQ, acts as a WISHBONE slave with a chosen termination and
//               delay, and compares bus and response behaviour against
//               expectations derived from the frame and slave behaviour.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_turfbus_ctrl;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        treq_n;
  logic        sreq_n;
  logic [7:0]  td;
  logic [7:0]  td_oe;
  logic        busy;
  logic        drop;
  logic        cyc, stb, we;
  logic [19:0] adr_o;
  logic [31:0] dat_o;
  logic [3:0]  sel_o;
  logic [31:0] dat_i;
  logic        ack, err, rty;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  turfbus_ctrl #(.WB_TIMEOUT(T)) dut (
    .wbm_clk_i   (clk),
    .wbm_rst_n_i (rst_n),
    .treq_n_i    (treq_n),
    .sreq_n_o    (sreq_n),
    .td_o        (td),
    .td_oe_o     (td_oe),
    .busy_o      (busy),
    .drop_o      (drop),
    .wbm_cyc_o   (cyc),
    .wbm_stb_o   (stb),
    .wbm_we_o    (we),
    .wbm_adr_o   (adr_o),
    .wbm_dat_o   (dat_o),
    .wbm_sel_o   (sel_o),
    .wbm_dat_i   (dat_i),
    .wbm_ack_i   (ack),
    .wbm_err_i   (err),
    .wbm_rty_i   (rty)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Shifts a frame in; returns just after the edge sampling its last bit.
  task automatic send_frame(input logic w, input logic [19:0] a, input logic [31:0] d);
    logic [53:0] frame;
    int nbits;
    frame = {1'b1, w, a, d};
    nbits = w ? 54 : 22;
    for (int i = 0; i < nbits; i++) begin
      treq_n = ~frame[53-i];
      tick();
      if (i == 0) chk("busy_after_start", 32'(busy), 32'd1);
    end
    treq_n = 1'b1;
  endtask

  // term = {rty, err, ack} driven by the slave 'delay' cycles after cyc rises
  // (never if term is 0). drop_at = response byte index at which a stray
  // start bit is injected, or -1.
  task automatic run_txn(input logic w, input logic [19:0] a, input logic [31:0] d,
                         input logic [2:0] term, input int delay,
                         input logic [31:0] rdata, input int drop_at);
    bit         terminated;
    int         cyc_len, len;
    logic [7:0] status;
    logic [7:0] exp_b [0:4];

    // Expected outcome from the slave behaviour alone.
    terminated = (term != 3'b000) && (delay < T);
    cyc_len    = terminated ? delay + 1 : T;
    if (!terminated)  status = 8'h03;
    else if (term[1]) status = 8'h01;
    else if (term[2]) status = 8'h02;
    else              status = 8'h00;
    len      = w ? 1 : 5;
    exp_b[0] = status;
    for (int k = 1; k < 5; k++)
      exp_b[k] = (status == 8'h00) ? 8'(rdata >> (8 * (4 - k))) : 8'h00;

    send_frame(w, a, d);
    chk("cyc_before_launch", 32'(cyc), 32'd0);
    tick();
    chk("cyc_launch", 32'(cyc), 32'd1);
    chk("stb_launch", 32'(stb), 32'd1);
    chk("we", 32'(we), 32'(w));
    chk("adr", 32'(adr_o), 32'(a));
    chk("sel", 32'(sel_o), 32'hF);
    if (w) chk("dat_o", dat_o, d);

    for (int c = 0; c < cyc_len; c++) begin
      chk("cyc_hold", 32'(cyc), 32'd1);
      if (terminated && c == delay) begin
        {rty, err, ack} = term;
        dat_i = rdata;
      end else begin
        {rty, err, ack} = 3'b000;
        dat_i = $urandom;
      end
      tick();
    end
    {rty, err, ack} = 3'b000;
    dat_i = $urandom;
    chk("cyc_end", 32'(cyc), 32'd0);
    chk("stb_end", 32'(stb), 32'd0);

    for (int b = 0; b < len + 2; b++) begin
      if (b < len) begin
        chk("sreq_active", 32'(sreq_n), 32'd0);
        chk("td_byte", 32'(td), 32'(exp_b[b]));
        chk("td_oe_on", 32'(td_oe), 32'hFF);
      end else begin
        chk("sreq_idle", 32'(sreq_n), 32'd1);
        chk("td_idle", 32'(td), 32'd0);
        chk("td_oe_off", 32'(td_oe), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
      end
      chk("drop", 32'(drop), 32'(drop_at >= 0 && b == drop_at + 1));
      treq_n = !(drop_at == b && b < len);
      tick();
    end
    treq_n = 1'b1;
  endtask

  initial begin
    rst_n  = 1'b0;
    treq_n = 1'b1;
    dat_i  = 32'h0;
    {rty, err, ack} = 3'b000;
    tick();
    tick();
    chk("rst_cyc", 32'(cyc), 32'd0);
    chk("rst_stb", 32'(stb), 32'd0);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_adr", 32'(adr_o), 32'd0);
    chk("rst_dat", dat_o, 32'd0);
    chk("rst_sel", 32'(sel_o), 32'hF);
    chk("rst_sreq", 32'(sreq_n), 32'd1);
    chk("rst_td", 32'(td), 32'd0);
    chk("rst_oe", 32'(td_oe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_drop", 32'(drop), 32'd0);
    rst_n = 1'b1;
    tick();

    // Directed cases.
    run_txn(1'b0, 20'hABCDE, 32'h0,        3'b001, 2, 32'hDEADBEEF, -1);
    run_txn(1'b1, 20'h00010, 32'h12345678, 3'b001, 0, 32'h0,        -1);
    run_txn(1'b0, 20'h12345, 32'h0,        3'b000, 0, 32'hCAFEF00D, -1);
    run_txn(1'b0, 20'h54321, 32'h0,        3'b011, 1, 32'h11223344, -1);
    run_txn(1'b1, 20'hFFFFF, 32'hA5A5A5A5, 3'b100, 3, 32'h0,        -1);
    run_txn(1'b0, 20'h0F0F0, 32'h0,        3'b001, T - 1, 32'h89ABCDEF, -1);
    run_txn(1'b0, 20'h33333, 32'h0,        3'b001, 1, 32'h01020304, 2);

    // Reset while the WB cycle is open.
    send_frame(1'b0, 20'h77777, 32'h0);
    tick();
    chk("rstwb_cyc_open", 32'(cyc), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstwb_cyc", 32'(cyc), 32'd0);
    chk("rstwb_stb", 32'(stb), 32'd0);
    chk("rstwb_oe", 32'(td_oe), 32'd0);
    chk("rstwb_sreq", 32'(sreq_n), 32'd1);
    chk("rstwb_busy", 32'(busy), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    run_txn(1'b0, 20'h24680, 32'h0, 3'b001, 1, 32'h13579BDF, -1);

    // Randomized transactions.
    for (int n = 0; n < 25; n++) begin
      logic       rw;
      logic [2:0] tm;
      int         dl, dp;
      rw = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0:       tm = 3'b000;
        1:       tm = 3'b001;
        2:       tm = 3'b010;
        3:       tm = 3'b100;
        4:       tm = 3'b011;
        default: tm = 3'b101;
      endcase
      dl = int'($urandom_range(0, T + 1));
      dp = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, rw ? 0 : 4)) : -1;
      run_txn(rw, 20'($urandom), $urandom, tm, dl, $urandom, dp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
